// File: rtl/isa_pkg.sv
// isa_pkg: shared encodings for the instruction sequencer.
//   - RV32 opcode / funct3 / funct7 constants for the supported subset
//   - ALU control encodings driven to the datapath
//   - sequencer FSM state type
//   - is_legal(): legality of a 32-bit instruction word
package isa_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_HALT
  } seq_state_t;

  // Only ADDI, ADD and BNE are executable; everything else halts.
  function automatic logic is_legal(input logic [31:0] ir);
    case (ir[6:0])
      OP_IMM:    return ir[14:12] == F3_ADD;
      OP_REG:    return (ir[14:12] == F3_ADD) && (ir[31:25] == F7_ADD);
      OP_BRANCH: return ir[14:12] == F3_BNE;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction-memory fetch port.
//   imem_req   : fetch request (sequencer -> memory)
//   imem_addr  : byte address of the fetch (sequencer -> memory)
//   imem_rdata : fetched instruction word (memory -> sequencer)
//   imem_valid : imem_rdata is valid this cycle (memory -> sequencer)
interface instr_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  imem_valid;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/instr_sequencer_imm_gen.sv
// imm_gen: combinational immediate extraction.
//   instr : raw instruction word
//   imm   : sign-extended I-immediate (OP_IMM), B-immediate (OP_BRANCH),
//           zero for every other opcode (ADD carries no immediate)
module imm_gen
  import isa_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] imm
);
  logic [11:0] i_imm;
  logic [12:0] b_imm;
  logic        unused_bits;

  assign i_imm = instr[31:20];
  // B-type scatters the offset; bit 0 is implicitly zero.
  assign b_imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign unused_bits = ^instr[19:12];

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_IMM:    imm = {{(DATA_WIDTH-12){i_imm[11]}}, i_imm};
      OP_BRANCH: imm = {{(DATA_WIDTH-13){b_imm[12]}}, b_imm};
      default:   imm = '0;
    endcase
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute control for the
// register-file/ALU datapath. One instruction in flight at a time.
//   clk, rst  : clock, async active-high reset
//   imem      : fetch port (master side of instr_sequencer_if)
//   EQ        : ALU equality flag, resolves BNE at the EXEC edge
//   ImmOp, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd : datapath controls
//   pc        : current program counter
//   halted    : sticky, set on an illegal instruction, cleared by rst only
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALUctrl_WIDTH = 3,
  parameter int PC_WIDTH      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  instr_sequencer_if.master        imem,
  input  logic                     EQ,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     RegWrite,
  output logic [ALUctrl_WIDTH-1:0] ALUctrl,
  output logic                     ALUsrc,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic [PC_WIDTH-1:0]      pc,
  output logic                     halted
);
  seq_state_t            state;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] imm_next;
  logic [6:0]            new_op;
  logic [PC_WIDTH-1:0]   pc_seq;
  logic [PC_WIDTH-1:0]   pc_br;

  // Decode fields are registered straight from the fetched word so they are
  // already visible during the DECODE cycle.
  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm (
    .instr (imem.imem_rdata),
    .imm   (imm_next)
  );

  assign new_op = imem.imem_rdata[6:0];
  assign pc_seq = pc + PC_WIDTH'(4);
  assign pc_br  = pc + PC_WIDTH'(ImmOp);

  // The request is a pure state decode so the very first FETCH after reset
  // already drives it; gating with rst keeps it low while reset is held.
  assign imem.imem_req  = ((state == S_FETCH) || (state == S_WAIT)) && !rst;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      ImmOp    <= '0;
      RegWrite <= 1'b0;
      ALUctrl  <= '0;
      ALUsrc   <= 1'b0;
      rs1      <= '0;
      rs2      <= '0;
      rd       <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (imem.imem_valid) begin
            ir      <= imem.imem_rdata;
            rs1     <= ADDRESS_WIDTH'(imem.imem_rdata[19:15]);
            rs2     <= ADDRESS_WIDTH'(imem.imem_rdata[24:20]);
            rd      <= ADDRESS_WIDTH'(imem.imem_rdata[11:7]);
            ImmOp   <= imm_next;
            ALUsrc  <= (new_op == OP_IMM);
            ALUctrl <= (new_op == OP_BRANCH) ? ALUctrl_WIDTH'(ALU_SUB)
                                             : ALUctrl_WIDTH'(ALU_ADD);
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_legal(ir[31:0])) begin
            RegWrite <= (ir[6:0] != OP_BRANCH);
            state    <= S_EXEC;
          end else begin
            halted <= 1'b1;
            state  <= S_HALT;
          end
        end
        S_EXEC: begin
          RegWrite <= 1'b0;
          // BNE: EQ=1 means operands equal, so the branch falls through.
          pc    <= ((ir[6:0] == OP_BRANCH) && !EQ) ? pc_br : pc_seq;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule
